// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer (instr_fetch_seq).
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF      = 10;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned INSTR_W         = BYTE_W * BYTES_PER_INSTR;
  localparam int unsigned CNT_W           = $clog2(BYTES_PER_INSTR);

  localparam logic [INSTR_W-1:0] INSTR_NOP = INSTR_W'(0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Fetch request/IF-ID handshake plus byte-wide ROM port of instr_fetch_seq.
// FETCH_ALIGN_CHECK_EN adds the misalign_o flag.
interface instr_fetch_seq_if
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic                req_i;
  logic [31:0]         pc_i;
  logic                flush_i;
  logic                stall_i;
  logic                ready_o;
  logic [ADDR_W-1:0]   rom_addr_o;
  logic [BYTE_W-1:0]   rom_data_i;
  logic [INSTR_W-1:0]  instr_o;
  logic                valid_o;
`ifdef FETCH_ALIGN_CHECK_EN
  logic                misalign_o;

  modport master (
    output req_i, pc_i, flush_i, stall_i, rom_data_i,
    input  ready_o, rom_addr_o, instr_o, valid_o, misalign_o
  );
  modport slave (
    input  req_i, pc_i, flush_i, stall_i, rom_data_i,
    output ready_o, rom_addr_o, instr_o, valid_o, misalign_o
  );
`else
  modport master (
    output req_i, pc_i, flush_i, stall_i, rom_data_i,
    input  ready_o, rom_addr_o, instr_o, valid_o
  );
  modport slave (
    input  req_i, pc_i, flush_i, stall_i, rom_data_i,
    output ready_o, rom_addr_o, instr_o, valid_o
  );
`endif
endinterface

// File: rtl/instr_fetch_seq_byte_packer.sv
// Shadow register that collects ROM bytes into a big-endian instruction word.
module instr_byte_packer
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic [BYTE_W-1:0]  i_data,
  output logic [INSTR_W-1:0] o_word_c
);

  logic [INSTR_W-1:0] r_shadow;
  logic [INSTR_W-1:0] w_merged;

  // Current byte dropped into its lane; byte 0 is the most significant.
  always_comb begin
    w_merged = r_shadow;
    for (int unsigned k = 0; k < BYTES_PER_INSTR; k++) begin
      if (i_cnt == CNT_W'(k)) begin
        w_merged[INSTR_W - BYTE_W*(k+1) +: BYTE_W] = i_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shadow <= '0;
    end else if (i_load) begin
      r_shadow <= w_merged;
    end
  end

  assign o_word_c = w_merged;

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch sequencer: four byte reads from one shared ROM port into a 32-bit word.
// FETCH_ALIGN_CHECK_EN turns unaligned requests into a flagged NOP.
module instr_fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
)(
  input logic                clk,
  input logic                rst,
  instr_fetch_seq_if.slave   bus
);

  fetch_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]  r_base, w_base_nxt;
  logic [ADDR_W-1:0]  r_rom_addr, w_rom_addr_nxt;
  logic [INSTR_W-1:0] r_instr, w_instr_nxt;
  logic               r_valid, w_valid_nxt;
  logic               w_ready_c;
  logic               w_accept;
  logic               w_pack_load;
  logic               w_pack_clear;
  logic [INSTR_W-1:0] w_word;
  logic               w_unused_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               r_misalign, w_misalign_nxt;
`endif

  assign w_unused_pc = ^bus.pc_i[31:ADDR_W];

  instr_byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_pack_clear),
    .i_load   (w_pack_load),
    .i_cnt    (r_cnt),
    .i_data   (bus.rom_data_i),
    .o_word_c (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_base     <= '0;
      r_rom_addr <= '0;
      r_instr    <= INSTR_NOP;
      r_valid    <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_base     <= w_base_nxt;
      r_rom_addr <= w_rom_addr_nxt;
      r_instr    <= w_instr_nxt;
      r_valid    <= w_valid_nxt;
`ifdef FETCH_ALIGN_CHECK_EN
      r_misalign <= w_misalign_nxt;
`endif
    end
  end

  // Flush outranks everything; with req it is simply a redirected accept.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_base_nxt     = r_base;
    w_rom_addr_nxt = r_rom_addr;
    w_instr_nxt    = r_instr;
    w_valid_nxt    = r_valid;
    w_pack_load    = 1'b0;
    w_pack_clear   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    w_misalign_nxt = r_misalign;
`endif
    w_ready_c = (r_state == IDLE) || ((r_state == HOLD) && !bus.stall_i) || bus.flush_i;
    w_accept  = bus.req_i && w_ready_c;

    if (w_accept) begin
      w_state_nxt    = FETCH;
      w_cnt_nxt      = '0;
      w_base_nxt     = bus.pc_i[ADDR_W-1:0];
      w_rom_addr_nxt = bus.pc_i[ADDR_W-1:0];
      w_valid_nxt    = 1'b0;
      w_pack_clear   = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      w_misalign_nxt = 1'b0;
      if (bus.pc_i[1:0] != 2'b00) begin
        w_state_nxt    = HOLD;
        w_instr_nxt    = INSTR_NOP;
        w_valid_nxt    = 1'b1;
        w_misalign_nxt = 1'b1;
      end
`endif
    end else if (bus.flush_i) begin
      w_state_nxt    = IDLE;
      w_cnt_nxt      = '0;
      w_rom_addr_nxt = r_base;
      w_valid_nxt    = 1'b0;
      w_pack_clear   = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      w_misalign_nxt = 1'b0;
`endif
    end else begin
      case (r_state)
        FETCH: begin
          w_pack_load = 1'b1;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(BYTES_PER_INSTR - 1)) begin
            w_state_nxt    = HOLD;
            w_instr_nxt    = w_word;
            w_valid_nxt    = 1'b1;
            w_rom_addr_nxt = r_base;
`ifdef FETCH_ALIGN_CHECK_EN
            w_misalign_nxt = 1'b0;
`endif
          end else begin
            w_rom_addr_nxt = r_base + ADDR_W'(r_cnt + CNT_W'(1));
          end
        end
        HOLD: begin
          if (!bus.stall_i) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            w_misalign_nxt = 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o    = w_ready_c;
  assign bus.rom_addr_o = r_rom_addr;
  assign bus.instr_o    = r_instr;
  assign bus.valid_o    = r_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.misalign_o = r_misalign;
`endif

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: directed scenarios plus random traffic vs a transaction model.
module tb_instr_fetch_seq;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned ROM_SZ = 1 << ADDR_W;
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rom [0:ROM_SZ-1];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  instr_fetch_seq_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_seq #(.ADDR_W(ADDR_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.rom_data_i = rom[bus.rom_addr_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: phase 0 = no instruction, 1..4 = waiting for byte (phase-1), 5 = presenting.
  int          m_phase = 0;
  logic [9:0]  m_base  = '0;
  logic [31:0] m_word  = '0;
  logic [31:0] m_instr = '0;
  logic        m_valid = 1'b0;
  logic        m_mis   = 1'b0;

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < 4; k++) w = {w[23:0], rom[a + 10'(k)]};
    return w;
  endfunction

  always @(negedge clk) begin
    logic       exp_ready;
    logic [9:0] exp_addr;
    exp_ready = (m_phase == 0) || (m_phase == 5 && !bus.stall_i) || bus.flush_i;
    exp_addr  = (m_phase >= 1 && m_phase <= 4) ? m_base + 10'(m_phase - 1) : m_base;
    if (chk_en && !rst) begin
      check("valid_o",    32'(bus.valid_o),    32'(m_valid));
      check("instr_o",    bus.instr_o,         m_instr);
      check("rom_addr_o", 32'(bus.rom_addr_o), 32'(exp_addr));
      check("ready_o",    32'(bus.ready_o),    32'(exp_ready));
`ifdef FETCH_ALIGN_CHECK_EN
      check("misalign_o", 32'(bus.misalign_o), 32'(m_mis));
`endif
    end
    // Predict the effect of the coming rising edge.
    if (rst) begin
      m_phase = 0; m_base = '0; m_instr = '0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (bus.req_i && exp_ready) begin
      m_base  = bus.pc_i[9:0];
      m_word  = rom_word(bus.pc_i[9:0]);
      m_phase = 1; m_valid = 1'b0; m_mis = 1'b0;
      if (ALIGN_CHK && bus.pc_i[1:0] != 2'b00) begin
        m_phase = 5; m_instr = 32'h0; m_valid = 1'b1; m_mis = 1'b1;
      end
    end else if (bus.flush_i) begin
      m_phase = 0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (m_phase == 4) begin
      m_phase = 5; m_instr = m_word; m_valid = 1'b1; m_mis = 1'b0;
    end else if (m_phase >= 1 && m_phase <= 3) begin
      m_phase++;
    end else if (m_phase == 5 && !bus.stall_i) begin
      m_phase = 0; m_valid = 1'b0; m_mis = 1'b0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle_inputs();
    bus.req_i = 1'b0; bus.pc_i = '0; bus.flush_i = 1'b0; bus.stall_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(ROM_SZ); i++) rom[i] = 8'($urandom);
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;
    rom[10'h3FE] = 8'hAA; rom[10'h3FF] = 8'hBB;
    idle_inputs();
    bus.req_i = 1'b1;
    step(2);
    rst = 1'b0;
    idle_inputs();
    chk_en = 1'b1;
    #1;
    check("reset valid", 32'(bus.valid_o), 32'h0);
    check("reset instr", bus.instr_o, 32'h0);
    check("reset addr", 32'(bus.rom_addr_o), 32'h0);
    check("reset ready", 32'(bus.ready_o), 32'h1);

    // Basic fetch from 0.
    bus.req_i = 1'b1; bus.pc_i = 32'h0;
    step(); bus.req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check("basic addr", 32'(bus.rom_addr_o), 32'(k));
      step();
    end
    #1 check("basic valid", 32'(bus.valid_o), 32'h1);
    check("basic instr", bus.instr_o, 32'h12345678);
    step();
    #1 check("basic valid drop", 32'(bus.valid_o), 32'h0);
    step();

    // Address wrap at the top of the ROM.
    rom[0] = 8'hCC; rom[1] = 8'hDD;
    bus.req_i = 1'b1; bus.pc_i = 32'h3FE;
    step(); bus.req_i = 1'b0;
`ifndef FETCH_ALIGN_CHECK_EN
    #1 check("wrap addr0", 32'(bus.rom_addr_o), 32'h3FE);
    step(); #1 check("wrap addr1", 32'(bus.rom_addr_o), 32'h3FF);
    step(); #1 check("wrap addr2", 32'(bus.rom_addr_o), 32'h000);
    step(); #1 check("wrap addr3", 32'(bus.rom_addr_o), 32'h001);
    step(); #1 check("wrap instr", bus.instr_o, 32'hAABBCCDD);
`else
    #1 check("misalign valid", 32'(bus.valid_o), 32'h1);
    check("misalign instr", bus.instr_o, 32'h0);
    check("misalign flag", 32'(bus.misalign_o), 32'h1);
    step(4);
`endif
    step(2);
    rom[0] = 8'h12; rom[1] = 8'h34;

    // Stall in HOLD, then back-to-back accept of pc 4.
    bus.req_i = 1'b1; bus.pc_i = 32'h0; bus.stall_i = 1'b1;
    step(); bus.pc_i = 32'h4;
    step(4);
    for (int k = 0; k < 3; k++) begin
      #1 check("stall instr", bus.instr_o, 32'h12345678);
      check("stall addr", 32'(bus.rom_addr_o), 32'h0);
      step();
    end
    bus.stall_i = 1'b0;
    #1 check("release valid", 32'(bus.valid_o), 32'h1);
    step(); bus.req_i = 1'b0;
    #1 check("b2b addr", 32'(bus.rom_addr_o), 32'h4);
    check("b2b valid", 32'(bus.valid_o), 32'h0);
    step(6);

    // Flush redirect at cnt=2.
    bus.req_i = 1'b1; bus.pc_i = 32'h0;
    step(); bus.req_i = 1'b0;
    step(2);
    bus.flush_i = 1'b1; bus.req_i = 1'b1; bus.pc_i = 32'h10;
    step(); bus.flush_i = 1'b0; bus.req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 check("redirect addr", 32'(bus.rom_addr_o), 32'h10 + 32'(k));
      check("redirect no valid", 32'(bus.valid_o), 32'h0);
      step();
    end
    #1 check("redirect valid", 32'(bus.valid_o), 32'h1);
    step(2);

    // Reset in the middle of a fetch.
    bus.req_i = 1'b1; bus.pc_i = 32'h8;
    step(); bus.req_i = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    #1 check("midrst valid", 32'(bus.valid_o), 32'h0);
    check("midrst instr", bus.instr_o, 32'h0);
    check("midrst addr", 32'(bus.rom_addr_o), 32'h0);
    check("midrst ready", 32'(bus.ready_o), 32'h1);
    step(2);

    // Flush of a stalled held instruction.
    bus.req_i = 1'b1; bus.pc_i = 32'h8; bus.stall_i = 1'b1;
    step(); bus.req_i = 1'b0;
    step(4);
    #1 check("held valid", 32'(bus.valid_o), 32'h1);
    bus.flush_i = 1'b1;
    step(); bus.flush_i = 1'b0;
    #1 check("flush hold valid", 32'(bus.valid_o), 32'h0);
    bus.stall_i = 1'b0;
    step(2);

`ifdef FETCH_ALIGN_CHECK_EN
    bus.req_i = 1'b1; bus.pc_i = 32'h6;
    step(); bus.req_i = 1'b0;
    #1 check("pc6 valid", 32'(bus.valid_o), 32'h1);
    check("pc6 instr", bus.instr_o, 32'h0);
    check("pc6 misalign", 32'(bus.misalign_o), 32'h1);
    step(2);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      bus.req_i   = ($urandom_range(0, 99) < 55);
      bus.flush_i = ($urandom_range(0, 99) < 8);
      bus.stall_i = ($urandom_range(0, 99) < 40);
      bus.pc_i    = $urandom;
      if ($urandom_range(0, 99) < 70) bus.pc_i[1:0] = 2'b00;
      rst = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
